// File: rtl/vga_pkg.sv
// Shared types and default widths for the RLE pixel sequencer.
package vga_pkg;

  localparam int RUN_BITS   = 10;
  localparam int COLOR_BITS = 6;
  localparam int TOK_BITS   = RUN_BITS + COLOR_BITS;

  typedef struct packed {
    logic [RUN_BITS-1:0]   run;
    logic [COLOR_BITS-1:0] color;
  } rle_token_t;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    RESTART,
    FILL,
    RUN,
    END
  } seq_state_t;

endpackage

// File: rtl/rle_token_skid.sv
// One-entry prefetch register between the token stream and the current run.
module rle_token_skid #(
  parameter int RUN_BITS   = 10,
  parameter int COLOR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  pop,
  input  logic                  bypass,
  input  logic                  in_valid,
  input  logic [RUN_BITS-1:0]   in_run,
  input  logic [COLOR_BITS-1:0] in_col,
  output logic                  in_ready,
  output logic                  nxt_valid,
  output logic [RUN_BITS-1:0]   nxt_run,
  output logic [COLOR_BITS-1:0] nxt_col
);

  logic                  valid_reg;
  logic [RUN_BITS-1:0]   run_reg;
  logic [COLOR_BITS-1:0] col_reg;
  logic                  push;

  // Ready never looks at in_valid; a pop in the same cycle frees the slot.
  assign in_ready = enable && !flush && (!valid_reg || pop);
  // A bypassed token is written straight into the current run by the parent.
  assign push     = in_valid && in_ready && !bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      run_reg   <= '0;
      col_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (push) begin
      valid_reg <= 1'b1;
      run_reg   <= in_run;
      col_reg   <= in_col;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end

  assign nxt_valid = valid_reg;
  assign nxt_run   = run_reg;
  assign nxt_col   = col_reg;

endmodule

// File: rtl/rle_pixel_sequencer.sv
// Expands run-length tokens into a per-pixel colour stream paced by blanking,
// restarting the upstream reader on every vsync_pulse.
module rle_pixel_sequencer #(
  parameter int RUN_BITS   = vga_pkg::RUN_BITS,
  parameter int COLOR_BITS = vga_pkg::COLOR_BITS,
  parameter int TOK_BITS   = RUN_BITS + COLOR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blank,
  input  logic                  hsync_pulse,
  input  logic                  vsync_pulse,
  input  logic                  in_valid,
  input  logic [TOK_BITS-1:0]   in_data,
  output logic                  in_ready,
  output logic                  stream_restart,
  output logic [COLOR_BITS-1:0] pixel,
  output logic                  underrun,
  output logic [9:0]            line
);

  import vga_pkg::seq_state_t;
  import vga_pkg::WAIT_FRAME;
  import vga_pkg::RESTART;
  import vga_pkg::FILL;
  import vga_pkg::RUN;
  import vga_pkg::END;

  seq_state_t            state_reg;
  logic [RUN_BITS-1:0]   cur_run_reg;
  logic [COLOR_BITS-1:0] cur_col_reg;
  logic [COLOR_BITS-1:0] pixel_reg;
  logic                  underrun_reg;
  logic                  stream_restart_reg;
  logic [9:0]            line_reg;

  logic                  nxt_valid;
  logic [RUN_BITS-1:0]   nxt_run;
  logic [COLOR_BITS-1:0] nxt_col;
  logic [RUN_BITS-1:0]   in_run;
  logic [COLOR_BITS-1:0] in_col;
  logic                  in_seq;
  logic                  active;
  logic                  cur_empty;
  logic                  cur_last;
  logic                  load_now;
  logic                  bypass;
  logic                  to_cur;

  assign in_run    = in_data[TOK_BITS-1 -: RUN_BITS];
  assign in_col    = in_data[COLOR_BITS-1:0];
  assign in_seq    = (state_reg == FILL) || (state_reg == RUN);
  assign active    = in_seq && !blank;
  assign cur_empty = (cur_run_reg == '0);
  assign cur_last  = (cur_run_reg == RUN_BITS'(1));
  assign load_now  = active && cur_last && nxt_valid;
  // With no prefetch held, a token goes straight to cur if cur is (or is about to be) empty.
  assign bypass    = !nxt_valid && (cur_empty || (!blank && cur_last));
  assign to_cur    = in_valid && in_ready && bypass;

  rle_token_skid #(
    .RUN_BITS   (RUN_BITS),
    .COLOR_BITS (COLOR_BITS)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (vsync_pulse),
    .enable    (in_seq),
    .pop       (load_now),
    .bypass    (bypass),
    .in_valid  (in_valid),
    .in_run    (in_run),
    .in_col    (in_col),
    .in_ready  (in_ready),
    .nxt_valid (nxt_valid),
    .nxt_run   (nxt_run),
    .nxt_col   (nxt_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= WAIT_FRAME;
      cur_run_reg        <= '0;
      cur_col_reg        <= '0;
      pixel_reg          <= '0;
      underrun_reg       <= 1'b0;
      stream_restart_reg <= 1'b0;
      line_reg           <= '0;
    end else begin
      stream_restart_reg <= 1'b0;
      pixel_reg          <= '0;
      if (hsync_pulse && (state_reg == RUN || state_reg == END)) begin
        line_reg <= line_reg + 10'd1;
      end
      if (vsync_pulse) begin
        state_reg          <= RESTART;
        stream_restart_reg <= 1'b1;
        cur_run_reg        <= '0;
        underrun_reg       <= 1'b0;
        line_reg           <= '0;
      end else begin
        case (state_reg)
          RESTART: state_reg <= FILL;
          FILL, RUN: begin
            // An active cycle with nothing in cur is a starved pixel.
            if (active) begin
              if (cur_empty) begin
                underrun_reg <= 1'b1;
              end else begin
                pixel_reg   <= cur_col_reg;
                cur_run_reg <= cur_run_reg - RUN_BITS'(1);
              end
            end
            if (load_now) begin
              cur_run_reg <= nxt_run;
              cur_col_reg <= nxt_col;
            end else if (to_cur) begin
              cur_run_reg <= in_run;
              cur_col_reg <= in_col;
            end
            if ((load_now && nxt_run == '0) || (to_cur && in_run == '0)) begin
              state_reg <= END;
            end else if (state_reg == FILL && (!blank || (!cur_empty && nxt_valid))) begin
              state_reg <= RUN;
            end
          end
          WAIT_FRAME, END: ;
          default: state_reg <= WAIT_FRAME;
        endcase
      end
    end
  end

  assign pixel          = pixel_reg;
  assign underrun       = underrun_reg;
  assign stream_restart = stream_restart_reg;
  assign line           = line_reg;

endmodule
